ps2_keycode_rx: RTL

//  Receives device-to-host PS/2 keyboard frames and produces the 16-bit keycode
//  bus consumed by the seven-segment digit decoder and the tutor logic.

---
 rtl/ps2_keycode_if.sv | 22 ++
 rtl/ps2_keycode_rx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_if.sv
// Keycode bus from the PS/2 receiver to its consumers.
// The receiver drives it through master; readers use slave.
interface ps2_keycode_if;
  logic [15:0] keycode;
  logic        key_valid;
  logic        key_release;
  logic        frame_err;

  modport master (
    output keycode,
    output key_valid,
    output key_release,
    output frame_err
  );

  modport slave (
    input keycode,
    input key_valid,
    input key_release,
    input frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver producing {prev, last} keycode.
// Oversamples raw pins on clk; never drives the PS/2 lines.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_keycode_if.master kif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic [FW-1:0] flt_cnt;
  logic          filt_clk;
  logic          flip;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    sr, sr_d;
  logic          par, par_d;
  logic [TW-1:0] to_cnt, to_d;
  logic [15:0]   kc_q, kc_d;
  logic          kv_q, kv_d;
  logic          kr_q, kr_d;
  logic          fe_q, fe_d;
  logic          to_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // filt_clk flips on the FILTER_LEN-th consecutive differing sample
  assign flip = (clk_s2 != filt_clk) &&
                (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall = flip && filt_clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_cnt  <= '0;
      filt_clk <= 1'b1;
    end else if (clk_s2 == filt_clk) begin
      flt_cnt  <= '0;
    end else if (flip) begin
      flt_cnt  <= '0;
      filt_clk <= clk_s2;
    end else begin
      flt_cnt  <= flt_cnt + FW'(1);
    end
  end

  assign to_hit = (state_q != IDLE) &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt;
    sr_d      = sr;
    par_d     = par;
    to_d      = to_cnt;
    kc_d      = kc_q;
    kv_d      = 1'b0;
    kr_d      = 1'b0;
    fe_d      = 1'b0;
    if (state_q != IDLE) begin
      to_d = fall ? '0 : to_cnt + TW'(1);
    end
    // timeout beats a fall arriving in the same cycle
    if (to_hit) begin
      state_d = IDLE;
      fe_d    = 1'b1;
      to_d    = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (dat_s2) begin
            fe_d = 1'b1;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            to_d      = '0;
          end
        end
        DATA: begin
          sr_d      = {dat_s2, sr[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{sr, par})) begin
            kc_d = {kc_q[7:0], sr};
            kv_d = 1'b1;
            kr_d = (kc_q[7:0] == 8'hF0);
          end else begin
            fe_d = 1'b1;
          end
          state_d = IDLE;
          to_d    = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
      kc_q    <= '0;
      kv_q    <= 1'b0;
      kr_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt <= bit_cnt_d;
      sr      <= sr_d;
      par     <= par_d;
      to_cnt  <= to_d;
      kc_q    <= kc_d;
      kv_q    <= kv_d;
      kr_q    <= kr_d;
      fe_q    <= fe_d;
    end
  end

  assign kif.keycode     = kc_q;
  assign kif.key_valid   = kv_q;
  assign kif.key_release = kr_q;
  assign kif.frame_err   = fe_q;

endmodule
